n_bit_normalizer: RTL

- Sequential normalizer: the inverse of the LSL/LSR shifter. Given data A, it recovers the shift amount that left-justifies A (count leading zeros) or right-justifies it (count trailing zeros).
- Iterative design: one bit position per clock, early termination, start/busy/done handshake.
- Sits beside the ALU shifter. Feeds normalize/priority-encode results back to the datapath as a multicycle operation.

---
 rtl/n_bit_normalizer.sv | 105 ++++++++++
 1 files changed

// File: rtl/n_bit_normalizer.sv
// n_bit_normalizer
//   Iterative normalizer (inverse of the LSL/LSR shifter). Shifts the captured
//   operand one bit per clock until it is MSB-justified (ctrl=0) or LSB-justified
//   (ctrl=1), counting the shifts. An all-zero operand terminates immediately.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted only in idle
//   ctrl   in   direction: 0 = left (count leading zeros), 1 = right (trailing zeros)
//   a      in   operand, captured with start
//   f      out  normalized data (f == a shifted by cnt)
//   cnt    out  number of single-bit shifts applied
//   zero   out  operand was all zeros
//   busy   out  high while an operation is in progress (run and fin)
//   done   out  one-cycle pulse when f/cnt/zero are valid
module n_bit_normalizer #(
   parameter int unsigned max_s_bits = 3,
   localparam int unsigned d_width = 2 ** max_s_bits
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  ctrl,
   input  logic [d_width-1:0]    a,
   output logic [d_width-1:0]    f,
   output logic [max_s_bits-1:0] cnt,
   output logic                  zero,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StFin  = 2'b10
   } state_e;

   state_e                state_q, state_d;
   logic [d_width-1:0]    f_q, f_d;
   logic [max_s_bits-1:0] cnt_q, cnt_d;
   logic                  zero_q, zero_d;
   logic                  dir_q, dir_d;
   logic                  terminal;

   // Stop once the leading bit in the shift direction is set; a zero operand
   // would never get there, so it stops on the first run cycle.
   assign terminal = zero_q | (dir_q ? f_q[0] : f_q[d_width-1]);

   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      dir_d   = dir_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               f_d     = a;
               dir_d   = ctrl;
               cnt_d   = '0;
               zero_d  = (a == '0);
               state_d = StRun;
            end
         end
         StRun: begin
            if (terminal) begin
               state_d = StFin;
            end else begin
               f_d   = dir_q ? (f_q >> 1) : (f_q << 1);
               cnt_d = cnt_q + max_s_bits'(1);
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         f_q     <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         dir_q   <= dir_d;
      end
   end

   assign f    = f_q;
   assign cnt  = cnt_q;
   assign zero = zero_q;
   assign busy = (state_q == StRun) | (state_q == StFin);
   assign done = (state_q == StFin);

endmodule
